// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
// Optional round-robin conflict policy is enabled by defining IMEM_ARB_RR_EN.
package imem_arb_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned BUS_ADDR_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    // Request fields after the grant mux; write data travels separately.
    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic                  we;
    } req_t;

    // Word-aligned and inside the RAM; upper bits must be zero, never aliased.
    function automatic logic addr_legal(input logic [BUS_ADDR_W-1:0] addr,
                                        input int unsigned           addr_w);
        logic aligned;
        logic in_range;
        aligned  = (addr & BUS_ADDR_W'(WORD_BYTES - 1)) == '0;
        in_range = (addr >> (addr_w + 2)) == '0;
        return aligned && in_range;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Requester and RAM-macro signals of the instruction/data memory arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    import imem_arb_pkg::*;

    logic                  i_req_valid;
    logic                  i_req_ready;
    logic [BUS_ADDR_W-1:0] i_req_addr;
    logic                  i_resp_valid;
    logic [DATA_W-1:0]     i_resp_data;
    logic                  i_resp_err;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic [BUS_ADDR_W-1:0] d_req_addr;
    logic                  d_req_we;
    logic [DATA_W-1:0]     d_req_wdata;
    logic                  d_resp_valid;
    logic [DATA_W-1:0]     d_resp_data;
    logic                  d_resp_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
        input  d_req_valid, d_req_addr, d_req_we, d_req_wdata,
        output d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data, i_resp_err,
        output d_req_valid, d_req_addr, d_req_we, d_req_wdata,
        input  d_req_ready, d_resp_valid, d_resp_data, d_resp_err,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_arb_pick.sv
// Two-way grant between fetch (I) and load/store (D) requesters.
// IMEM_ARB_RR_EN: alternate winners on conflicts; otherwise D has fixed priority.
module imem_arb_pick (
    input  logic clk,
    input  logic reset_n,
    input  logic i_valid,
    input  logic d_valid,
    output logic i_gnt,
    output logic d_gnt
);

`ifdef IMEM_ARB_RR_EN
    // Winner of the most recent conflict was D; reset so I takes the first one.
    logic last_d_q;
    logic last_d_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    always_comb begin
        last_d_d = last_d_q;
        i_gnt    = i_valid && (!d_valid || last_d_q);
        d_gnt    = d_valid && (!i_valid || !last_d_q);
        if (i_valid && d_valid) begin
            last_d_d = d_gnt;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;

    always_comb begin
        d_gnt = d_valid;
        i_gnt = i_valid && !d_valid;
    end
`endif

endmodule

// File: rtl/imem_arbiter.sv
// Shares one registered-read single-port RAM between fetch and load/store ports.
// Conflict policy selected by IMEM_ARB_RR_EN (see imem_arb_pick).
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    imem_arbiter_if.slave  bus
);

    logic   i_gnt;
    logic   d_gnt;
    logic   acc;
    logic   legal;
    req_t   req;

    owner_e owner_q, owner_d;
    logic   err_q,   err_d;
    logic   wr_q,    wr_d;

    imem_arb_pick u_pick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (bus.i_req_valid),
        .d_valid (bus.d_req_valid),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt)
    );

    // Grant mux and RAM drive in the acceptance cycle.
    always_comb begin
        req = '{addr: bus.i_req_addr, we: 1'b0};
        if (d_gnt) begin
            req = '{addr: bus.d_req_addr, we: bus.d_req_we};
        end
        acc             = i_gnt || d_gnt;
        legal           = addr_legal(req.addr, ADDR_W);
        bus.i_req_ready = i_gnt;
        bus.d_req_ready = d_gnt;
        bus.mem_en      = acc && legal;
        bus.mem_we      = acc && legal && req.we;
        bus.mem_addr    = req.addr[ADDR_W+1:2];
        bus.mem_wdata   = bus.d_req_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
        end
    end

    // Owner of the response due next cycle; NONE when nothing was accepted.
    always_comb begin
        owner_d = OWN_NONE;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        if (d_gnt) begin
            owner_d = OWN_D;
        end else if (i_gnt) begin
            owner_d = OWN_I;
        end
        err_d = acc && !legal;
        wr_d  = d_gnt && req.we;
    end

    // Route the one-cycle response; only legal reads return RAM data.
    always_comb begin
        bus.i_resp_valid = owner_q == OWN_I;
        bus.d_resp_valid = owner_q == OWN_D;
        bus.i_resp_err   = bus.i_resp_valid && err_q;
        bus.d_resp_err   = bus.d_resp_valid && err_q;
        bus.i_resp_data  = '0;
        bus.d_resp_data  = '0;
        if (bus.i_resp_valid && !err_q) begin
            bus.i_resp_data = bus.mem_rdata;
        end
        if (bus.d_resp_valid && !err_q && !wr_q) begin
            bus.d_resp_data = bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed steps then random traffic,
// checked against a word-array reference model of the shared RAM.
module tb_imem_arbiter;
    import imem_arb_pkg::*;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef struct packed {
        logic              valid;
        logic              is_d;
        logic              err;
        logic [DATA_W-1:0] data;
    } exp_resp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM macro model: registered read, preload path used during reset.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_rdata;
    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [DATA_W-1:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rdata <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_rdata;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [DEPTH];
    exp_resp_t         pend;
    bit                last_win_d;
    bit                exp_ig, exp_dg;
    int                compared;
    int                mismatched;

    // Requested stimulus, applied at the next falling edge
    bit          iv, dv, dwe;
    logic [31:0] ia, da, dwd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 4 * DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return (4 * $urandom_range(0, 255)) | $urandom_range(1, 3);
        if (r == 1) return 32'h400 + 4 * $urandom_range(0, 1000);
        if (r == 2) return $urandom;
        return 4 * $urandom_range(0, 15);
    endfunction

    task automatic drive_idle();
        bus.i_req_valid = 1'b0;
        bus.i_req_addr  = '0;
        bus.d_req_valid = 1'b0;
        bus.d_req_addr  = '0;
        bus.d_req_we    = 1'b0;
        bus.d_req_wdata = '0;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_i_valid"}, 32'(bus.i_resp_valid), 0);
        chk({pfx, "_i_err"},   32'(bus.i_resp_err),   0);
        chk({pfx, "_i_data"},  bus.i_resp_data,        0);
        chk({pfx, "_d_valid"}, 32'(bus.d_resp_valid), 0);
        chk({pfx, "_d_err"},   32'(bus.d_resp_err),   0);
        chk({pfx, "_d_data"},  bus.d_resp_data,        0);
        chk({pfx, "_mem_en"},  32'(bus.mem_en),       0);
        chk({pfx, "_mem_we"},  32'(bus.mem_we),       0);
    endtask

    // One clock: apply stimulus, check grant/RAM drive and the response owed now.
    task automatic run_cycle();
        bit          acc, legal, wr;
        logic [31:0] a;
        exp_resp_t   nxt;
        @(negedge clk);
        bus.i_req_valid = iv;
        bus.i_req_addr  = ia;
        bus.d_req_valid = dv;
        bus.d_req_addr  = da;
        bus.d_req_we    = dwe;
        bus.d_req_wdata = dwd;
        #1;
        if (iv && dv) begin
`ifdef IMEM_ARB_RR_EN
            exp_dg = !last_win_d;
`else
            exp_dg = 1'b1;
`endif
            exp_ig     = !exp_dg;
            last_win_d = exp_dg;
        end else begin
            exp_ig = iv;
            exp_dg = dv;
        end
        acc   = exp_ig || exp_dg;
        a     = exp_dg ? da : ia;
        legal = acc && ref_legal(a);
        wr    = exp_dg && dwe;
        chk("i_ready", 32'(bus.i_req_ready), 32'(exp_ig));
        chk("d_ready", 32'(bus.d_req_ready), 32'(exp_dg));
        chk("mem_en",  32'(bus.mem_en),      32'(legal));
        chk("mem_we",  32'(bus.mem_we),      32'(legal && wr));
        if (legal) chk("mem_addr", 32'(bus.mem_addr), a / 4);
        if (legal && wr) chk("mem_wdata", bus.mem_wdata, dwd);

        chk("i_resp_valid", 32'(bus.i_resp_valid), 32'(pend.valid && !pend.is_d));
        chk("i_resp_err",   32'(bus.i_resp_err),   32'(pend.valid && !pend.is_d && pend.err));
        chk("i_resp_data",  bus.i_resp_data, (pend.valid && !pend.is_d) ? pend.data : 32'd0);
        chk("d_resp_valid", 32'(bus.d_resp_valid), 32'(pend.valid && pend.is_d));
        chk("d_resp_err",   32'(bus.d_resp_err),   32'(pend.valid && pend.is_d && pend.err));
        chk("d_resp_data",  bus.d_resp_data, (pend.valid && pend.is_d) ? pend.data : 32'd0);

        nxt = '0;
        if (acc) begin
            nxt.valid = 1'b1;
            nxt.is_d  = exp_dg;
            nxt.err   = !legal;
            if (legal) begin
                if (wr) ref_mem[ADDR_W'(a / 4)] = dwd;
                else    nxt.data = ref_mem[ADDR_W'(a / 4)];
            end
        end
        pend = nxt;
    endtask

    task automatic set_idle();
        iv = 0; ia = '0; dv = 0; da = '0; dwe = 0; dwd = '0;
    endtask

    initial begin
        bit ihold, dhold;
        compared   = 0;
        mismatched = 0;
        pend       = '0;
        last_win_d = 1'b1;
        pre_we     = 1'b0;
        pre_addr   = '0;
        pre_data   = '0;
        set_idle();
        drive_idle();
        reset_n = 1'b0;

        // Preload RAM through the macro model while held in reset
        for (int i = 0; i < int'(DEPTH); i++) begin
            @(negedge clk);
            pre_we   = 1'b1;
            pre_addr = ADDR_W'(i);
            pre_data = (i == 3) ? 32'hE2800001 : $urandom;
            ref_mem[i] = pre_data;
        end
        @(negedge clk);
        pre_we = 1'b0;
        #1;
        chk_quiet("reset");
        reset_n = 1'b1;

        // Single fetch of word 3
        iv = 1; ia = 32'h0000_000C;
        run_cycle();
        set_idle();
        run_cycle();
        chk("fetch_word3", bus.i_resp_data, 32'hE2800001);

        // D write then back-to-back read of the same word
        dv = 1; da = 32'h14; dwe = 1; dwd = 32'hDEADBEEF;
        run_cycle();
        dwe = 0; dwd = '0;
        run_cycle();
        set_idle();
        run_cycle();
        chk("d_readback", bus.d_resp_data, 32'hDEADBEEF);

        // Both ports continuously valid
        iv = 1; ia = 32'h10; dv = 1; da = 32'h20; dwe = 0;
        repeat (4) run_cycle();
        set_idle();
        run_cycle();

        // Misaligned fetch, then out-of-range data access
        iv = 1; ia = 32'h6;
        run_cycle();
        set_idle();
        dv = 1; da = 32'h400;
        run_cycle();
        set_idle();
        run_cycle();

        // Reset asserted while a D read is in flight
        dv = 1; da = 32'h14;
        run_cycle();
        set_idle();
        reset_n = 1'b0;
        drive_idle();
        pend       = '0;
        last_win_d = 1'b1;
        @(negedge clk);
        #1;
        chk_quiet("midreset");
        reset_n = 1'b1;
        run_cycle();
        iv = 1; ia = 32'h0000_000C;
        run_cycle();
        set_idle();
        run_cycle();
        chk("refetch_word3", bus.i_resp_data, 32'hE2800001);

        // Random traffic honouring the hold-until-accepted rule
        ihold = 0;
        dhold = 0;
        repeat (600) begin
            if (!ihold) begin
                iv = 1'($urandom_range(0, 1));
                ia = rand_addr();
            end
            if (!dhold) begin
                dv  = 1'($urandom_range(0, 1));
                da  = rand_addr();
                dwe = 1'($urandom_range(0, 1));
                dwd = $urandom;
            end
            run_cycle();
            ihold = iv && !exp_ig;
            dhold = dv && !exp_dg;
        end
        set_idle();
        run_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares one synchronous single-port instruction/data RAM between the fetch requester (I port, read-only) and the load/store requester (D port, read/write).
- Fits the design's single block-RAM budget: program and data live in one RAM with a registered read.
- Handles arbitration, word-alignment and range checking, and routes each 1-cycle-latency response back to its owner.
- Sits between the core's fetch/memory stages and the RAM macro.

Parameters:
- ADDR_W, 8, word-address width of the RAM (depth = 2**ADDR_W words).
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  fetch request valid.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_req_addr  in  32  fetch byte address.
- i_resp_valid  out  1  fetch response valid (one-cycle pulse).
- i_resp_data  out  DATA_W  fetched instruction.
- i_resp_err  out  1  fetch was misaligned or out of range.
- d_req_valid  in  1  data request valid.
- d_req_ready  out  1  data request accepted this cycle.
- d_req_addr  in  32  data byte address.
- d_req_we  in  1  1 = word write, 0 = read.
- d_req_wdata  in  DATA_W  write data.
- d_resp_valid  out  1  data response valid (one-cycle pulse; also acks writes).
- d_resp_data  out  DATA_W  read data; 0 for writes and errors.
- d_resp_err  out  1  data request was misaligned or out of range.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address, taken from req_addr[ADDR_W+1:2].
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset:
  - All *_resp_valid, *_resp_err, mem_en and mem_we are 0; resp data is 0; owner register = NONE.
  - Round-robin pointer is set so that I wins the first conflict.
  - Reset asserted mid-transaction drops the in-flight response; no response pulse follows reset release.
- Request handshake:
  - A transfer occurs when valid && ready.
  - Requesters hold addr/we/wdata stable while valid && !ready and must not drop valid before acceptance.
  - ready is combinational: ready = valid && granted. ready depends on valid and must not be used to form valid.
- Grant:
  - At most one port is granted per cycle.
  - Only one port valid: that port is granted.
  - Both valid: the policy below decides.
- Throughput: one accepted request per cycle, back-to-back. No stall cycles and no limit on outstanding requests beyond the single pipeline stage.
- Access:
  - An accepted legal request drives mem_en=1, mem_addr, mem_we (D writes only) and mem_wdata combinationally in the acceptance cycle.
  - The owner register is set to I or D.
- Legality:
  - Illegal if addr[1:0] != 0 or addr[31:ADDR_W+2] != 0.
  - An illegal accepted request drives mem_en=0 and records owner with an err flag.
- Response timing:
  - Exactly 1 cycle after acceptance, the owner's resp_valid pulses high for one cycle.
  - Read data = mem_rdata passed through combinationally in that cycle.
  - Write and error responses return data = 0; err is set only for illegal requests.
  - Responses cannot be backpressured.
  - A response and a new acceptance in the same cycle are both legal, for the same or a different port.
- Owner register: transitions NONE / I / D every cycle: next = granted port, or NONE if nothing was accepted.
- Address wrap: none. Out-of-range addresses are errors, not aliased.

Optional Feature:
- Macro: IMEM_ARB_RR_EN.
- Defined: on a conflict, grant the port that did not win the most recent conflict. The pointer updates only on conflicts.
- Undefined: fixed priority, D always beats I. The pointer logic is not built. Fetch may starve during continuous D traffic; this is accepted.

Decomposition:
- Package imem_arb_pkg:
  - typedef enum owner_e {OWN_NONE, OWN_I, OWN_D}.
  - WORD_BYTES = 4.
  - Helper function addr_legal(addr, ADDR_W).
- One sub-module, imem_arb_pick:
  - Combinational 2-way grant plus the optional round-robin pointer flop.
  - Inputs: clk, reset_n, i_valid, d_valid. Outputs: i_gnt, d_gnt.

Test Plan:
- Single fetch: preload RAM[3]=32'hE2800001; I reads addr 0x0C -> i_req_ready same cycle, mem_addr=3; next cycle i_resp_valid=1, data=32'hE2800001, err=0.
- D write then read: write 32'hDEADBEEF to 0x14, then read 0x14 back-to-back -> write ack d_resp_valid with data 0; following cycle read response DEADBEEF; no idle cycles.
- Conflict, macro undefined: I and D both valid for 3 cycles -> D granted all 3 cycles, i_req_ready=0 throughout.
- Conflict, IMEM_ARB_RR_EN defined: both continuously valid for 4 cycles -> grants I,D,I,D.
- Errors: I addr 0x0000_0006 (misaligned) and D addr 0x0000_0400 with ADDR_W=8 (out of range) -> mem_en=0; resp_err=1, data 0 next cycle on the respective port.
- Reset mid-op: accept a D read, assert reset_n=0 before the next edge -> d_resp_valid stays 0; after release the first fetch behaves as the single-fetch case.
